// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM state encoding
// and the 16-bit bit-reverse helper used to turn right shifts into left shifts.
package shift_pkg;

    localparam int W   = 16;
    localparam int SHW = 4;

    // Op codes presented by the requesters
    localparam logic [1:0] SH_LSR = 2'b00;
    localparam logic [1:0] SH_ASR = 2'b01;
    localparam logic [1:0] SH_LSL = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS0 = 2'd1;
    localparam logic [1:0] ST_PASS1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit-reverse of a 16-bit word (bit 0 <-> bit 15, ...)
    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_right.sv
// Logical right barrel shifter: log2(W) stages, each optionally shifting by 2^i.
module barrel_right
    import shift_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = 4
) (
    input  logic [W-1:0]   data,
    input  logic [SHW-1:0] amt,
    output logic [W-1:0]   result
);

    // Cascade of power-of-two shift stages, zero-filling from the top
    always_comb begin
        logic [W-1:0] stage_s;
        stage_s = data;
        for (int i = 0; i < SHW; i++) begin
            if (amt[i]) begin
                stage_s = stage_s >> (1 << i);
            end else begin
                stage_s = stage_s;
            end
        end
        result = stage_s;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shares one right barrel shifter between two requesters. A round-robin
// arbiter accepts one op at a time; the FSM runs one or two shifter passes
// and combines the pass results into LSR/ASR/LSL/ROR.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_amt,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_id,
    output logic        busy
);

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic        last_grant_r;
    logic [1:0]  op_r;
    logic [15:0] data_r;
    logic [3:0]  amt_r;
    logic        id_r;
    logic [15:0] p0_r;
    logic [15:0] p1_r;
    logic        resp_valid_r;
    logic        busy_r;

    logic        any_valid_s;
    logic        grant_id_s;
    logic        accept_s;
    logic [15:0] sh_in_s;
    logic [3:0]  sh_amt_s;
    logic [15:0] sh_out_s;
    logic        two_pass_s;
    logic [15:0] result_s;

    // Round-robin pick: on a tie the requester that did not win last time goes
    always_comb begin
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_grant_r;
        end else begin
            grant_id_s = req1_valid;
        end
        accept_s   = ~rst && (state_r == ST_IDLE) && any_valid_s;
        req0_ready = accept_s && (grant_id_s == 1'b0);
        req1_ready = accept_s && (grant_id_s == 1'b1);
    end

    // Shifter input mux: only latched operands feed the shifter
    always_comb begin
        sh_in_s  = 16'h0000;
        sh_amt_s = 4'd0;
        case (state_r)
            ST_PASS0: begin
                sh_in_s  = (op_r == SH_LSL) ? rev16(data_r) : data_r;
                sh_amt_s = amt_r;
            end
            ST_PASS1: begin
                if (op_r == SH_ASR) begin
                    sh_in_s  = 16'hFFFF;
                    sh_amt_s = amt_r;
                end else begin
                    // ROR second pass: left part comes from rev(data) >> (16-n) mod 16
                    sh_in_s  = rev16(data_r);
                    sh_amt_s = 4'd0 - amt_r;
                end
            end
            default: begin
                sh_in_s  = 16'h0000;
                sh_amt_s = 4'd0;
            end
        endcase
    end

    barrel_right #(.W(W), .SHW(SHW)) u_barrel_right (
        .data   (sh_in_s),
        .amt    (sh_amt_s),
        .result (sh_out_s)
    );

    assign two_pass_s = (op_r == SH_ASR) || (op_r == SH_ROR);

    // Combine the registered pass results into the final value for the op
    always_comb begin
        result_s = 16'h0000;
        case (op_r)
            SH_LSR: result_s = p0_r;
            SH_LSL: result_s = rev16(p0_r);
            SH_ASR: result_s = p0_r | (data_r[15] ? ~p1_r : 16'h0000);
            SH_ROR: result_s = p0_r | ((amt_r == 4'd0) ? 16'h0000 : rev16(p1_r));
            default: result_s = 16'h0000;
        endcase
    end

    // Next-state logic of the sequencer FSM
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_PASS0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PASS0: begin
                if (two_pass_s) begin
                    next_state_s = ST_PASS1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_PASS1: next_state_s = ST_DONE;
            ST_DONE: begin
                if (resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, operand latch, pass registers and response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= 1'b1;
            op_r         <= 2'b00;
            data_r       <= 16'h0000;
            amt_r        <= 4'd0;
            id_r         <= 1'b0;
            p0_r         <= 16'h0000;
            p1_r         <= 16'h0000;
            resp_valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant_id_s;
                        id_r         <= grant_id_s;
                        op_r         <= grant_id_s ? req1_op   : req0_op;
                        data_r       <= grant_id_s ? req1_data : req0_data;
                        amt_r        <= grant_id_s ? req1_amt  : req0_amt;
                    end else begin
                        last_grant_r <= last_grant_r;
                    end
                end
                ST_PASS0: begin
                    p0_r <= sh_out_s;
                    if (!two_pass_s) begin
                        resp_valid_r <= 1'b1;
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                ST_PASS1: begin
                    p1_r         <= sh_out_s;
                    resp_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: resp_valid_r <= 1'b0;
            endcase
        end
    end

    // Response fields are pure decodes of registers, so they hold still in DONE
    assign resp_valid = resp_valid_r;
    assign resp_data  = result_s;
    assign resp_id    = id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic        resp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from requester id, check latency/result/id, then drain it
    task automatic do_op(input logic id, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] a, input logic [15:0] exp, input int lat,
                         input string tag);
        int cyc;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_data = d; req1_amt = a;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_data = d; req0_amt = a;
        end
        #1;
        chk({tag, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = ~d; req1_data = ~d; req0_amt = ~a; req1_amt = ~a;
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_data"}, {16'd0, resp_data}, {16'd0, exp});
        chk({tag, "_id"}, {31'd0, resp_id}, {31'd0, id});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_drain"}, {30'd0, resp_valid, busy}, 32'd0);
    endtask

    initial begin
        logic [3:0] grants;
        int ng;
        logic [15:0] held_data;

        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_data = 16'h0000; req0_amt = 4'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_data = 16'h0000; req1_amt = 4'd0;
        step(); step();
        chk("reset_outputs", {27'd0, resp_valid, busy, resp_id, req0_ready, req1_ready}, 32'd0);
        chk("reset_data", {16'd0, resp_data}, 32'd0);
        rst = 1'b0;

        // Basic ops
        do_op(1'b0, SH_LSR, 16'hF0F0, 4'd4,  16'h0F0F, 2, "lsr");
        do_op(1'b1, SH_ASR, 16'h8000, 4'd3,  16'hF000, 3, "asr_neg");
        do_op(1'b1, SH_ASR, 16'h4000, 4'd3,  16'h0800, 3, "asr_pos");
        do_op(1'b0, SH_LSL, 16'h0001, 4'd15, 16'h8000, 2, "lsl15");
        do_op(1'b0, SH_ROR, 16'h0001, 4'd1,  16'h8000, 3, "ror1");
        do_op(1'b0, SH_ROR, 16'h1234, 4'd0,  16'h1234, 3, "ror0");
        do_op(1'b1, SH_ROR, 16'h1234, 4'd4,  16'h4123, 3, "ror4");
        do_op(1'b1, SH_ASR, 16'hA5A5, 4'd0,  16'hA5A5, 3, "asr0");
        do_op(1'b0, SH_LSL, 16'h1234, 4'd4,  16'h2340, 2, "lsl4");
        do_op(1'b1, SH_LSR, 16'hFFFF, 4'd15, 16'h0001, 2, "lsr15");

        // Arbitration: fresh reset, both requesting continuously
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = SH_LSR; req0_data = 16'h0002; req0_amt = 4'd1;
        req1_valid = 1'b1; req1_op = SH_LSR; req1_data = 16'h0004; req1_amt = 4'd1;
        grants = 4'b0000;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                chk("arb_both_ready", 32'd1, 32'd0);
            end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                grants[ng] = req1_ready;
                ng++;
            end
            if (resp_valid === 1'b1) begin
                chk("arb_resp_data", {16'd0, resp_data}, resp_id ? 32'h0002 : 32'h0001);
            end
            @(negedge clk);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("arb_count", ng, 4);
        chk("arb_order", {28'd0, grants}, 32'b1010);
        repeat (4) step();
        resp_ready = 1'b0;
        chk("arb_idle", {31'd0, busy}, 32'd0);

        // Backpressure in DONE
        @(negedge clk);
        req0_valid = 1'b1; req0_op = SH_LSR; req0_data = 16'h00FF; req0_amt = 4'd4;
        #1;
        chk("bp_accept", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk("bp_valid", {31'd0, resp_valid}, 32'd1);
        held_data = resp_data;
        chk("bp_data", {16'd0, held_data}, 32'h000F);
        req1_valid = 1'b1; req1_op = SH_LSR; req1_data = 16'h0100; req1_amt = 4'd8;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold", {13'd0, resp_valid, busy, resp_id, resp_data}, {13'd0, 1'b1, 1'b1, 1'b0, 16'h000F});
            chk("bp_no_grant", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("bp_release", {29'd0, resp_valid, busy, req1_ready}, 32'b001);
        req1_valid = 1'b0;
        step();

        // Reset during PASS1 of an ASR
        @(negedge clk);
        req0_valid = 1'b1; req0_op = SH_ASR; req0_data = 16'h8000; req0_amt = 4'd2;
        #1;
        chk("rst_accept", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk("rst_in_pass1", {30'd0, busy, resp_valid}, 32'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears", {14'd0, resp_valid, busy, resp_data}, 32'd0);
        repeat (3) begin
            step();
            chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_op(1'b0, SH_LSR, 16'h8421, 4'd1, 16'h4210, 2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
